// File: rtl/tiny_axi_pkg.sv
// Shared constants for the tiny_axi request-channel blocks.
package tiny_axi_pkg;

    typedef enum logic [1:0] {
        REQC_IDLE = 2'b00,
        REQC_AREQ = 2'b01,
        REQC_BOUT = 2'b10,
        REQC_ERR  = 2'b11
    } reqc_state_t;

    localparam logic [5:0] ATOP_NONE = 6'b000000;

endpackage

// File: rtl/sfifo.sv
// Show-ahead synchronous FIFO with occupancy count; writes when full and reads
// when empty are ignored.
module sfifo #(
    parameter int SFIFODW = 8,
    parameter int SFIFOAW = 2,
    parameter int SFIFODP = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wen,
    input  logic [SFIFODW-1:0] wdata,
    input  logic               ren,
    output logic [SFIFODW-1:0] rdata,
    output logic               full,
    output logic               empty,
    output logic [SFIFOAW:0]   count
);

    logic [SFIFODW-1:0] mem [SFIFODP];
    logic [SFIFOAW-1:0] wptr;
    logic [SFIFOAW-1:0] rptr;
    logic               do_w;
    logic               do_r;

    assign full  = (count == (SFIFOAW+1)'(SFIFODP));
    assign empty = (count == '0);
    assign do_w  = wen & ~full;
    assign do_r  = ren & ~empty;
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_w) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_w) wptr <= wptr + SFIFOAW'(1);
            if (do_r) rptr <= rptr + SFIFOAW'(1);
            case ({do_w, do_r})
                2'b10:   count <= count + (SFIFOAW+1)'(1);
                2'b01:   count <= count - (SFIFOAW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/req_chan_mngr_p.sv
// Request-channel manager: queues requests, arbitrates for the request bus,
// issues tagged a_* transfers under an outstanding limit, feeds tag+wdata onward.
module req_chan_mngr_p
    import tiny_axi_pkg::*;
#(
    parameter int              MIDW     = 2,
    parameter logic [MIDW-1:0] MID      = 2'b00,
    parameter int              TAGW     = 2,
    parameter int              AW       = 32,
    parameter int              DW       = 128,
    parameter int              QAW      = 2,
    parameter int              MAX_OUTS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 req_rq,
    input  logic                 gnt_rq,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [MIDW+TAGW-1:0] a_id,
    output logic [AW-1:0]        a_addr,
    output logic                 a_write,
    output logic [5:0]           a_atop,
    input  logic                 start_rq,
    output logic                 start_ready,
    input  logic [AW-1:0]        in_addr,
    input  logic                 in_write,
    input  logic [DW-1:0]        in_data,
    output logic                 next_rq,
    output logic [MIDW+TAGW-1:0] next_id,
    output logic [DW-1:0]        next_data,
    input  logic                 ren_id_data,
    input  logic                 rsp_done,
    output logic [TAGW:0]        outs_cnt,
    output logic                 ovf_err,
    output logic [1:0]           dbg_state
);

    localparam int AFW = TAGW + 1 + AW;
    localparam int DFW = TAGW + DW;
    localparam logic [TAGW:0]   MAX_C = (TAGW+1)'(MAX_OUTS);
    localparam logic [TAGW+1:0] MAX_W = (TAGW+2)'(MAX_OUTS);

    reqc_state_t     state;
    logic [TAGW-1:0] tag;
    logic [AFW-1:0]  a_head;
    logic [DFW-1:0]  d_head;
    logic [QAW:0]    a_cnt;
    logic [QAW:0]    d_cnt;
    logic            a_full, a_empty, d_full, d_empty;
    logic            push, can_issue, chain_ok, rsp_take;
    logic            unused_dfifo;

    assign start_ready = ~a_full;
    assign push        = start_rq & start_ready;
    assign next_rq     = a_valid & a_ready;

    sfifo #(.SFIFODW(AFW), .SFIFOAW(QAW), .SFIFODP(2**QAW)) u_addr_fifo (
        .clk(clk), .rst_n(rst_n), .wen(push), .wdata({tag, in_write, in_addr}),
        .ren(next_rq), .rdata(a_head), .full(a_full), .empty(a_empty), .count(a_cnt)
    );

    sfifo #(.SFIFODW(DFW), .SFIFOAW(QAW), .SFIFODP(2**QAW)) u_data_fifo (
        .clk(clk), .rst_n(rst_n), .wen(push), .wdata({tag, in_data}),
        .ren(ren_id_data), .rdata(d_head), .full(d_full), .empty(d_empty), .count(d_cnt)
    );

    assign unused_dfifo = &{1'b0, d_full, d_empty, d_cnt};

    // a_valid/a_ready: a transfer occurs on any cycle with both high (next_rq);
    // once a_valid rises, a_* hold steady because only next_rq pops the addr FIFO.
    assign a_id      = {MID, a_head[AFW-1 -: TAGW]};
    assign a_write   = a_head[AW];
    assign a_addr    = a_head[AW-1:0];
    assign a_atop    = ATOP_NONE;
    assign next_id   = {MID, d_head[DFW-1 -: TAGW]};
    assign next_data = d_head[DW-1:0];
    assign dbg_state = state;

    assign can_issue = ~a_empty & (outs_cnt < MAX_C);
    // Keep the bus only if another request is already queued and one more may go out.
    assign chain_ok  = gnt_rq & (a_cnt >= (QAW+1)'(2)) &
                       (({1'b0, outs_cnt} + (TAGW+2)'(1)) < MAX_W);
    assign rsp_take  = rsp_done & (outs_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= REQC_IDLE;
            req_rq  <= 1'b0;
            a_valid <= 1'b0;
        end else begin
            case (state)
                REQC_IDLE: if (can_issue) begin
                    state  <= REQC_AREQ;
                    req_rq <= 1'b1;
                end
                REQC_AREQ: if (gnt_rq) begin
                    state   <= REQC_BOUT;
                    a_valid <= 1'b1;
                end
                REQC_BOUT: if (a_ready && !chain_ok) begin
                    state   <= REQC_IDLE;
                    req_rq  <= 1'b0;
                    a_valid <= 1'b0;
                end
                REQC_ERR: begin
                    req_rq  <= 1'b0;
                    a_valid <= 1'b0;
                end
                default: state <= REQC_ERR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag      <= '0;
            outs_cnt <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (push) tag <= tag + TAGW'(1);
            if (start_rq && !start_ready) ovf_err <= 1'b1;
            case ({next_rq, rsp_take})
                2'b10:   outs_cnt <= outs_cnt + (TAGW+1)'(1);
                2'b01:   outs_cnt <= outs_cnt - (TAGW+1)'(1);
                default: outs_cnt <= outs_cnt;
            endcase
        end
    end

endmodule
